// File: rtl/rxfifo_rd_machine.sv
// RX FIFO read machine: drains framed records (header + N payload words) from the RX FIFO,
// emits a header descriptor pulse and a valid/ready payload stream, and drops over-length records.
module rxfifo_rd_machine #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_FRAME_WORDS = 512,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxfifo_empty,
    output logic                  rxfifo_rd_en,
    input  logic [DATA_WIDTH-1:0] rxfifo_dread,
    input  logic                  rxfifo_valid,
    input  logic                  rxfifo_underflow,
    output logic                  hdr_valid,
    output logic [15:0]           hdr_tag,
    output logic [15:0]           hdr_len,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  err_underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_WAIT,
        S_PAY_REQ,
        S_PAY_WAIT,
        S_PAY_OUT,
        S_DROP_REQ,
        S_DROP_WAIT
    } state_t;

    localparam logic [15:0] LP_MAX_LEN = 16'(MAX_FRAME_WORDS);

    state_t                r_state;
    state_t                w_next;
    logic                  w_rd_en;
    logic [15:0]           w_hdr_len;
    logic [15:0]           w_hdr_tag;
    logic                  w_over_len;
    logic                  w_last_word;

    logic                  r_hdr_valid;
    logic [15:0]           r_hdr_tag;
    logic [15:0]           r_hdr_len;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_frame_done;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic                  r_err_underflow;
    logic [15:0]           r_remaining;

    assign w_hdr_tag   = rxfifo_dread[31:16];
    assign w_hdr_len   = rxfifo_dread[15:0];
    assign w_over_len  = (w_hdr_len > LP_MAX_LEN);
    assign w_last_word = (r_remaining == 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read strobe is combinational from the request states so it lasts exactly one cycle.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        if (reset) begin
            w_next = S_IDLE;
        end else if (rxfifo_underflow) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!rxfifo_empty) begin
                        w_rd_en = 1'b1;
                        w_next  = S_HDR_WAIT;
                    end
                end
                S_HDR_WAIT: begin
                    if (rxfifo_valid) begin
                        if (w_over_len) begin
                            w_next = S_DROP_REQ;
                        end else if (w_hdr_len == 16'd0) begin
                            w_next = S_IDLE;
                        end else begin
                            w_next = S_PAY_REQ;
                        end
                    end
                end
                S_PAY_REQ: begin
                    if (!rxfifo_empty) begin
                        w_rd_en = 1'b1;
                        w_next  = S_PAY_WAIT;
                    end
                end
                S_PAY_WAIT: begin
                    if (rxfifo_valid) begin
                        w_next = S_PAY_OUT;
                    end
                end
                S_PAY_OUT: begin
                    if (out_ready) begin
                        w_next = w_last_word ? S_IDLE : S_PAY_REQ;
                    end
                end
                S_DROP_REQ: begin
                    if (!rxfifo_empty) begin
                        w_rd_en = 1'b1;
                        w_next  = S_DROP_WAIT;
                    end
                end
                S_DROP_WAIT: begin
                    if (rxfifo_valid) begin
                        w_next = w_last_word ? S_IDLE : S_DROP_REQ;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr_valid     <= 1'b0;
            r_hdr_tag       <= '0;
            r_hdr_len       <= '0;
            r_out_data      <= '0;
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_cnt     <= '0;
            r_drop_cnt      <= '0;
            r_err_underflow <= 1'b0;
            r_remaining     <= '0;
        end else begin
            r_hdr_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            // Underflow abandons the partial record without counting it.
            if (rxfifo_underflow) begin
                r_err_underflow <= 1'b1;
                r_out_valid     <= 1'b0;
                r_out_last      <= 1'b0;
            end else begin
                case (r_state)
                    S_HDR_WAIT: begin
                        if (rxfifo_valid) begin
                            r_hdr_tag   <= w_hdr_tag;
                            r_hdr_len   <= w_hdr_len;
                            r_remaining <= w_hdr_len;
                            if (!w_over_len) begin
                                r_hdr_valid <= 1'b1;
                                if (w_hdr_len == 16'd0) begin
                                    r_frame_done <= 1'b1;
                                    r_frame_cnt  <= r_frame_cnt + CNT_WIDTH'(1);
                                end
                            end
                        end
                    end
                    S_PAY_WAIT: begin
                        if (rxfifo_valid) begin
                            r_out_data  <= rxfifo_dread;
                            r_out_valid <= 1'b1;
                            r_out_last  <= w_last_word;
                        end
                    end
                    S_PAY_OUT: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_remaining <= r_remaining - 16'd1;
                            if (w_last_word) begin
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    S_DROP_WAIT: begin
                        if (rxfifo_valid) begin
                            r_remaining <= r_remaining - 16'd1;
                            if (w_last_word) begin
                                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rxfifo_rd_en  = w_rd_en;
    assign hdr_valid     = r_hdr_valid;
    assign hdr_tag       = r_hdr_tag;
    assign hdr_len       = r_hdr_len;
    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign out_last      = r_out_last;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
    assign drop_cnt      = r_drop_cnt;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_rxfifo_rd_machine.sv
// Bench for rxfifo_rd_machine: a queue-based FIFO responder feeds records and a record-level
// parser of the same word list predicts headers, payload stream, and counters.
module tb_rxfifo_rd_machine;

    localparam int DW   = 32;
    localparam int MAXW = 512;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rxfifo_empty;
    logic          rxfifo_rd_en;
    logic [DW-1:0] rxfifo_dread;
    logic          rxfifo_valid;
    logic          rxfifo_underflow;
    logic          hdr_valid;
    logic [15:0]   hdr_tag;
    logic [15:0]   hdr_len;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;
    logic          err_underflow;

    always #5 clk = ~clk;

    rxfifo_rd_machine #(
        .DATA_WIDTH(DW),
        .MAX_FRAME_WORDS(MAXW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rxfifo_empty(rxfifo_empty),
        .rxfifo_rd_en(rxfifo_rd_en),
        .rxfifo_dread(rxfifo_dread),
        .rxfifo_valid(rxfifo_valid),
        .rxfifo_underflow(rxfifo_underflow),
        .hdr_valid(hdr_valid),
        .hdr_tag(hdr_tag),
        .hdr_len(hdr_len),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt),
        .err_underflow(err_underflow)
    );

    int checks = 0;
    int errors = 0;

    // FIFO responder state
    logic [31:0] q[$];
    logic [31:0] stim[$];
    bit          pend = 1'b0;
    int          pend_dly = 0;
    logic [31:0] pend_word = '0;
    int          lat_max = 1;
    bit          starve = 1'b0;
    int          rdy_mode = 0;
    int          bp_cnt = 0;
    bit          uf_mode = 1'b0;
    bit          uf_arm = 1'b0;
    bit          uf_fired = 1'b0;

    // Observed and expected record-level streams
    logic [31:0] obs_hdr[$];
    logic [32:0] obs_pay[$];
    logic [31:0] exp_hdr[$];
    logic [32:0] exp_pay[$];
    int          obs_done = 0;
    int          exp_done = 0;
    int          rd_count = 0;
    int          exp_rd = 0;
    int          exp_frames = 0;
    int          exp_drops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        pre_rd;
        logic        pre_ov;
        logic        pre_last;
        logic [31:0] pre_data;
        bit          pre_stall;
        bit          hs;
        pre_rd    = rxfifo_rd_en;
        pre_ov    = out_valid;
        pre_last  = out_last;
        pre_data  = out_data;
        pre_stall = (pre_ov === 1'b1) && (out_ready === 1'b0) && !reset;
        hs        = (pre_ov === 1'b1) && (out_ready === 1'b1) && !reset;
        if (hs) obs_pay.push_back({pre_last, pre_data});
        @(posedge clk);
        #1;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pre_rd === 1'b1) begin
                rd_count++;
                check("one_outstanding", 64'(pend), 64'(0));
                check("rd_not_empty", 64'(q.size() != 0), 64'(1));
                pend      = 1'b1;
                pend_dly  = int'($urandom_range(1, lat_max));
                pend_word = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
            end
            if (hdr_valid === 1'b1) begin
                obs_hdr.push_back({hdr_tag, hdr_len});
                check("hdr_before_out", 64'(out_valid), 64'(0));
                if (hdr_len == 16'd0) check("zero_len_done", 64'(frame_done), 64'(1));
                if (uf_mode) uf_arm = 1'b1;
            end
            if (frame_done === 1'b1) obs_done++;
            if (hs) check("done_after_last", 64'(frame_done), 64'(pre_last));
            if (pre_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(pre_data));
                check("hold_last", 64'(out_last), 64'(pre_last));
            end
        end
        rxfifo_valid     = 1'b0;
        rxfifo_underflow = 1'b0;
        rxfifo_dread     = $urandom;
        if (pend) begin
            pend_dly--;
            if (pend_dly <= 0) begin
                pend         = 1'b0;
                rxfifo_valid = 1'b1;
                rxfifo_dread = pend_word;
                if (uf_arm) begin
                    rxfifo_underflow = 1'b1;
                    uf_arm   = 1'b0;
                    uf_mode  = 1'b0;
                    uf_fired = 1'b1;
                    q.delete();
                end
            end
        end
        rxfifo_empty = (q.size() == 0) || (starve && ($urandom_range(0, 3) == 0));
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (out_valid === 1'b1 && bp_cnt < 10) begin
                    out_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    out_ready = 1'b1;
                    if (out_valid !== 1'b1) bp_cnt = 0;
                end
            end
        endcase
        #1;
    endtask

    // Record-level parse of the word list: header, then len payload words; over-length is dropped.
    task automatic model_stim();
        int          i;
        logic [31:0] hw;
        logic [15:0] len;
        i = 0;
        while (i < stim.size()) begin
            hw  = stim[i];
            len = hw[15:0];
            if (len > 16'(MAXW)) begin
                exp_drops++;
            end else begin
                exp_hdr.push_back(hw);
                exp_frames++;
                exp_done++;
                for (int k = 1; k <= int'(len); k++) exp_pay.push_back({(k == int'(len)), stim[i + k]});
            end
            i += 1 + int'(len);
        end
        foreach (stim[j]) q.push_back(stim[j]);
        exp_rd += stim.size();
    endtask

    task automatic drain(input int budget);
        int idle;
        int n;
        idle = 0;
        n = 0;
        while (idle < 8 && n < budget) begin
            tick();
            n++;
            if (q.size() == 0 && !pend && out_valid !== 1'b1 && !rxfifo_valid) idle++;
            else idle = 0;
        end
        check("drain_idle", 64'(idle), 64'(8));
    endtask

    task automatic clear_obs();
        obs_hdr.delete();
        obs_pay.delete();
        exp_hdr.delete();
        exp_pay.delete();
        obs_done = 0;
        exp_done = 0;
        rd_count = 0;
        exp_rd   = 0;
    endtask

    task automatic compare_all(input string nm);
        check({nm, "_hdr_n"}, 64'(obs_hdr.size()), 64'(exp_hdr.size()));
        for (int i = 0; i < exp_hdr.size() && i < obs_hdr.size(); i++)
            check({nm, "_hdr"}, 64'(obs_hdr[i]), 64'(exp_hdr[i]));
        check({nm, "_pay_n"}, 64'(obs_pay.size()), 64'(exp_pay.size()));
        for (int i = 0; i < exp_pay.size() && i < obs_pay.size(); i++)
            check({nm, "_pay"}, 64'(obs_pay[i]), 64'(exp_pay[i]));
        check({nm, "_done_n"}, 64'(obs_done), 64'(exp_done));
        check({nm, "_rd_n"}, 64'(rd_count), 64'(exp_rd));
        check({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(16'(exp_frames)));
        check({nm, "_drop_cnt"}, 64'(drop_cnt), 64'(16'(exp_drops)));
        clear_obs();
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_rd_en"}, 64'(rxfifo_rd_en), 64'(0));
        check({nm, "_hdr_valid"}, 64'(hdr_valid), 64'(0));
        check({nm, "_hdr_tag"}, 64'(hdr_tag), 64'(0));
        check({nm, "_hdr_len"}, 64'(hdr_len), 64'(0));
        check({nm, "_out_data"}, 64'(out_data), 64'(0));
        check({nm, "_out_valid"}, 64'(out_valid), 64'(0));
        check({nm, "_out_last"}, 64'(out_last), 64'(0));
        check({nm, "_frame_done"}, 64'(frame_done), 64'(0));
        check({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
        check({nm, "_drop_cnt"}, 64'(drop_cnt), 64'(0));
        check({nm, "_err_uf"}, 64'(err_underflow), 64'(0));
    endtask

    task automatic gen_random_batch(input int nrec);
        int r;
        int len;
        stim.delete();
        repeat (nrec) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) len = 0;
            else if (r <= 7) len = int'($urandom_range(1, 6));
            else if (r == 8) len = int'($urandom_range(7, 20));
            else len = MAXW + 1 + int'($urandom_range(0, 5));
            stim.push_back({16'($urandom), 16'(len)});
            repeat (len) stim.push_back($urandom);
        end
    endtask

    initial begin
        reset            = 1'b1;
        rxfifo_empty     = 1'b1;
        rxfifo_valid     = 1'b0;
        rxfifo_underflow = 1'b0;
        rxfifo_dread     = '0;
        out_ready        = 1'b1;

        // Power-on reset
        repeat (3) tick();
        check_reset_state("por");
        reset = 1'b0;
        tick();

        // Single record
        stim = '{32'h00AB0003, 32'h11, 32'h22, 32'h33};
        model_stim();
        drain(2000);
        compare_all("single");

        // Backpressure: ready held low 10 cycles per word
        rdy_mode = 2;
        stim = '{32'h00AB0003, 32'h11, 32'h22, 32'h33};
        model_stim();
        drain(2000);
        compare_all("bp");
        rdy_mode = 0;

        // Zero length
        stim = '{32'h00050000};
        model_stim();
        drain(2000);
        compare_all("zero");

        // Over-length (513) followed by a valid len=1 record
        stim.delete();
        stim.push_back(32'h00CC0201);
        repeat (513) stim.push_back($urandom);
        stim.push_back(32'h00DD0001);
        stim.push_back(32'h00000077);
        model_stim();
        drain(20000);
        compare_all("overlen");

        // Maximum accepted length with random ready
        rdy_mode = 1;
        stim.delete();
        stim.push_back(32'h00EE0200);
        repeat (512) stim.push_back($urandom);
        model_stim();
        drain(20000);
        compare_all("maxlen");

        // Randomized batches: variable FIFO latency, sporadic empty, random ready
        lat_max = 3;
        starve  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            gen_random_batch(10);
            model_stim();
            drain(30000);
            compare_all("rand");
        end
        lat_max  = 1;
        starve   = 1'b0;
        rdy_mode = 0;

        // Underflow injected together with the first payload word's valid
        uf_mode  = 1'b1;
        uf_fired = 1'b0;
        q.push_back(32'h00310002);
        q.push_back(32'h000000A1);
        q.push_back(32'h000000A2);
        for (int n = 0; n < 50 && !uf_fired; n++) tick();
        check("uf_fired", 64'(uf_fired), 64'(1));
        tick();
        check("uf_err", 64'(err_underflow), 64'(1));
        check("uf_out_valid", 64'(out_valid), 64'(0));
        repeat (5) tick();
        check("uf_err_sticky", 64'(err_underflow), 64'(1));
        check("uf_out_valid_idle", 64'(out_valid), 64'(0));
        check("uf_frame_cnt", 64'(frame_cnt), 64'(16'(exp_frames)));
        check("uf_hdr_n", 64'(obs_hdr.size()), 64'(1));
        check("uf_pay_n", 64'(obs_pay.size()), 64'(0));
        check("uf_done_n", 64'(obs_done), 64'(0));
        check("uf_rd_n", 64'(rd_count), 64'(2));
        clear_obs();
        stim = '{32'h00320001, 32'h000000B1};
        model_stim();
        drain(2000);
        compare_all("post_uf");
        check("post_uf_err", 64'(err_underflow), 64'(1));

        // Starvation after 1 of 3 payload words, then reset mid-record
        q.push_back(32'h00770003);
        q.push_back(32'h00000044);
        repeat (40) tick();
        check("starve_hdr_n", 64'(obs_hdr.size()), 64'(1));
        if (obs_hdr.size() > 0) check("starve_hdr", 64'(obs_hdr[0]), 64'(32'h00770003));
        check("starve_pay_n", 64'(obs_pay.size()), 64'(1));
        if (obs_pay.size() > 0) check("starve_pay", 64'(obs_pay[0]), 64'({1'b0, 32'h00000044}));
        check("starve_done_n", 64'(obs_done), 64'(0));
        check("starve_rd_n", 64'(rd_count), 64'(2));
        check("starve_rd_en", 64'(rxfifo_rd_en), 64'(0));
        reset = 1'b1;
        tick();
        check_reset_state("mid_rst");
        reset = 1'b0;
        exp_frames = 0;
        exp_drops  = 0;
        clear_obs();
        tick();
        stim = '{32'h00990001, 32'h00000055};
        model_stim();
        drain(2000);
        compare_all("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
